mod_reduce_pipe: RTL and testbench

Multi-lane, fully pipelined reducer modulo the Raccoon prime q = 2^QW − 2^K + 1 (default 33292289), for double-width products (< 2^(2·QW)). It sits between the NTT/pointwise multipliers and the coefficient memory. Relative to the single-lane fixed-width reducer it adds:
- parametrised modulus shape and lane count;
- a valid/ready handshake with full back-pressure;
- a per-transaction tag;
- a per-transaction centered-output mode.

---
 rtl/raccoon_pkg.sv | 24 ++
 rtl/mod_reduce_pipe_if.sv | 28 ++
 rtl/mod_reduce_lane.sv | 95 +++++++++
 rtl/mod_reduce_pipe.sv | 76 +++++++
 tb/tb_mod_reduce_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raccoon_pkg.sv
// Shared constants and helpers for reduction modulo q = 2^QW - 2^K + 1.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package raccoon_pkg;

   localparam int QW = 25;
   localparam int K  = 18;

   // Modulus for a given shape; 64-bit so any sensible QW fits.
   function automatic longint q_of(input int qw, input int k);
      return (longint'(1) << qw) - (longint'(1) << k) + longint'(1);
   endfunction

   // Number of S1 shift terms: every i with qw + i*(qw-k) < 2*qw.
   function automatic int n_terms(input int qw, input int k);
      int d;
      d = qw - k;
      return (qw + d - 1) / d;
   endfunction

   localparam longint Q      = q_of(QW, K);
   localparam longint HALF_Q = (Q - 1) / 2;

endpackage

// File: rtl/mod_reduce_pipe_if.sv
// Input/output stream bundle of the modular reducer.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; master drives requests, slave is the reducer.
interface mod_reduce_pipe_if #(
   parameter int QW    = raccoon_pkg::QW,
   parameter int LANES = 4,
   parameter int TAGW  = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*2*QW-1:0]    in_data;
   logic                     in_center;
   logic [TAGW-1:0]          in_tag;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*(QW+1)-1:0]  out_data;
   logic [TAGW-1:0]          out_tag;

   modport master (
      output in_valid, in_data, in_center, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_center, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/mod_reduce_lane.sv
// One lane of the reducer: quotient estimate, remainder, final correction/centering.
// Latency: 3 enabled cycles from x to y.
// Backpressure: all registers hold while en is low; no valid tracking here.
module mod_reduce_lane #(
   parameter int QW = raccoon_pkg::QW,
   parameter int K  = raccoon_pkg::K
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [2*QW-1:0] x,
   input  logic            center,
   output logic [QW:0]     y
);
   import raccoon_pkg::*;

   localparam int D  = QW - K;
   localparam int NT = n_terms(QW, K);
   localparam int RW = QW + 3;

   localparam logic [RW-1:0] Q1   = RW'(q_of(QW, K));
   localparam logic [RW-1:0] Q2   = RW'(2 * q_of(QW, K));
   localparam logic [RW-1:0] Q3   = RW'(3 * q_of(QW, K));
   localparam logic [QW:0]   QO   = (QW+1)'(q_of(QW, K));
   localparam logic [QW-1:0] HALF = QW'((q_of(QW, K) - 1) / 2);

   // r is known to lie in [-q, 4q), so only the low RW bits of x matter after S1.
   logic [RW-1:0] x_s1;
   logic [QW:0]   p_s1;
   logic [QW:0]   p_next;
   logic [RW-1:0] p_w;
   logic [RW-1:0] r_next;
   logic [RW-1:0] r_q;
   logic [QW-1:0] res;
   logic [QW:0]   y_next;

   // Quotient estimate: sum of x shifted by QW, QW+D, QW+2D, ...
   always_comb begin
      p_next = '0;
      for (int i = 0; i < NT; i++) begin
         p_next = p_next + (QW+1)'(x >> (QW + i * D));
      end
   end

   // S1 registers: truncated x and quotient estimate.
   always_ff @(posedge clk) begin
      if (en) begin
         x_s1 <= x[RW-1:0];
         p_s1 <= p_next;
      end
   end

   // Remainder r = x - p*q, with p*q built from shifts; wraps cleanly in RW bits.
   always_comb begin
      p_w    = RW'(p_s1);
      r_next = x_s1 - ((p_w << QW) - (p_w << K) + p_w);
   end

   // S2 register: signed remainder.
   always_ff @(posedge clk) begin
      if (en) begin
         r_q <= r_next;
      end
   end

   // Bring r into [0, q) and optionally fold into the centered range.
   always_comb begin
      if (r_q[RW-1]) begin
         res = QW'(r_q + Q1);
      end else if (r_q >= Q3) begin
         res = QW'(r_q - Q3);
      end else if (r_q >= Q2) begin
         res = QW'(r_q - Q2);
      end else if (r_q >= Q1) begin
         res = QW'(r_q - Q1);
      end else begin
         res = QW'(r_q);
      end
      if (center && (res > HALF)) begin
         y_next = {1'b0, res} - QO;
      end else begin
         y_next = {1'b0, res};
      end
   end

   // S3 register: lane output, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         y <= '0;
      end else if (en) begin
         y <= y_next;
      end
   end

endmodule

// File: rtl/mod_reduce_pipe.sv
// Multi-lane pipelined reducer modulo q with tag and per-transaction centered mode.
// Latency: 3 cycles, 1 transaction/cycle when out_ready is high.
// Backpressure: whole pipe freezes while S3 is valid and out_ready is low; in_ready drops.
module mod_reduce_pipe #(
   parameter int QW    = raccoon_pkg::QW,
   parameter int K     = raccoon_pkg::K,
   parameter int LANES = 4,
   parameter int TAGW  = 8
) (
   input logic               clk,
   input logic               rst,
   mod_reduce_pipe_if.slave  bus
);
   import raccoon_pkg::*;

   logic                    adv;
   logic [2:0]              vld;
   logic [TAGW-1:0]         tag_s1;
   logic [TAGW-1:0]         tag_s2;
   logic [TAGW-1:0]         tag_s3;
   logic                    center_s1;
   logic                    center_s2;
   logic [LANES*(QW+1)-1:0] lane_out;

   // Reset term keeps in_ready high while reset is held; the pipe is being flushed anyway.
   assign adv           = ~vld[2] | bus.out_ready | ~rst;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld[2];
   assign bus.out_tag   = tag_s3;
   assign bus.out_data  = lane_out;

   // Valid bits shift with the data; bubbles travel as zeros.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld <= '0;
      end else if (adv) begin
         vld <= {vld[1:0], bus.in_valid};
      end
   end

   // Tag and mode follow the data; inputs only sampled on an accepted transaction.
   always_ff @(posedge clk) begin
      if (adv && bus.in_valid) begin
         tag_s1    <= bus.in_tag;
         center_s1 <= bus.in_center;
      end
      if (adv) begin
         tag_s2    <= tag_s1;
         center_s2 <= center_s1;
      end
   end

   // Output tag register, cleared with the outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_s3 <= '0;
      end else if (adv) begin
         tag_s3 <= tag_s2;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mod_reduce_lane #(
         .QW (QW),
         .K  (K)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (adv),
         .x      (bus.in_data[i*2*QW +: 2*QW]),
         .center (center_s2),
         .y      (lane_out[i*(QW+1) +: QW+1])
      );
   end

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// Bench for mod_reduce_pipe: directed table, reset/stall sequences, random streams.
// Latency: checks the 3-cycle path and full-rate streaming.
// Backpressure: random out_ready with a queue-based reference model.
module tb_mod_reduce_pipe;

   localparam longint QR = (64'sd1 <<< 25) - (64'sd1 <<< 18) + 1;   // 33292289
   localparam longint HR = (QR - 1) / 2;
   localparam longint QA = 7681;
   localparam longint HA = 3840;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mod_reduce_pipe_if #(.QW(25), .LANES(4), .TAGW(8)) bus_a ();
   mod_reduce_pipe_if #(.QW(13), .LANES(1), .TAGW(8)) bus_b ();

   mod_reduce_pipe #(.QW(25), .K(18), .LANES(4), .TAGW(8)) u_dut (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   mod_reduce_pipe #(.QW(13), .K(9), .LANES(1), .TAGW(8)) u_alt (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_out, rdy_low, first_out, last_out;

   typedef struct packed {
      logic [199:0] x;
      logic         c;
      logic [103:0] y;
   } vec_t;
   typedef struct packed { logic [103:0] y; logic [7:0] tag; } ea_t;
   typedef struct packed { logic [13:0]  y; logic [7:0] tag; } eb_t;

   vec_t tv [5];
   ea_t  q_a [$];
   eb_t  q_b [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain x mod q, then fold into centered range when selected.
   function automatic logic [25:0] ref_a(input longint x, input bit c);
      longint m;
      m = x % QR;
      if (c && m > HR) m = m - QR;
      return 26'(m);
   endfunction

   function automatic logic [13:0] ref_b(input longint x, input bit c);
      longint m;
      m = x % QA;
      if (c && m > HA) m = m - QA;
      return 14'(m);
   endfunction

   function automatic logic [103:0] exp_a(input logic [199:0] x, input bit c);
      logic [103:0] y;
      for (int l = 0; l < 4; l++) y[l*26 +: 26] = ref_a(longint'(x[l*50 +: 50]), c);
      return y;
   endfunction

   function automatic logic [199:0] px(input longint a0, input longint a1, input longint a2, input longint a3);
      return {50'(a3), 50'(a2), 50'(a1), 50'(a0)};
   endfunction

   function automatic logic [103:0] py(input longint a0, input longint a1, input longint a2, input longint a3);
      return {26'(a3), 26'(a2), 26'(a1), 26'(a0)};
   endfunction

   function automatic longint rand_x50();
      longint v;
      if ($urandom_range(0, 9) == 0) begin
         case ($urandom_range(0, 5))
            0:       v = 0;
            1:       v = QR - 1;
            2:       v = QR;
            3:       v = (64'sd1 <<< 50) - 1;
            4:       v = QR * longint'($urandom_range(0, 33800000));
            default: v = (QR - 1) * (QR - 1);
         endcase
      end else begin
         v = longint'({$urandom, $urandom}) & ((64'sd1 <<< 50) - 1);
      end
      return v;
   endfunction

   // Remainder bound: r must stay within [-q, 4q) whenever S2 holds a transaction.
   for (genvar g = 0; g < 4; g++) begin : g_rchk
      longint rv;
      always @(negedge clk) begin
         if (rst && u_dut.vld[1]) begin
            rv = longint'($signed(u_dut.g_lane[g].u_lane.r_q));
            n_tests++;
            if (rv < -QR || rv >= 4 * QR) begin
               n_fail++;
               $display("FAIL r_range lane %0d: r=%0d required [-q,4q)", g, rv);
            end
         end
      end
   end

   longint rv_b;
   always @(negedge clk) begin
      if (rst && u_alt.vld[1]) begin
         rv_b = longint'($signed(u_alt.g_lane[0].u_lane.r_q));
         n_tests++;
         if (rv_b < -QA || rv_b >= 4 * QA) begin
            n_fail++;
            $display("FAIL r_range_alt: r=%0d required [-q,4q)", rv_b);
         end
      end
   end

   task automatic stream_a(input int n, input int pv, input int pr);
      int       sent, cyc;
      bit       hold;
      logic [7:0] tagc;
      ea_t      e;
      sent = 0; cyc = 0; hold = 0; tagc = 8'($urandom);
      n_out = 0; rdy_low = 0; first_out = -1; last_out = -1;
      while ((sent < n || q_a.size() > 0) && cyc < 60000) begin
         if (!hold) begin
            bus_a.in_valid  = (sent < n) && ($urandom_range(0, 99) < pv);
            bus_a.in_data   = px(rand_x50(), rand_x50(), rand_x50(), rand_x50());
            bus_a.in_center = 1'($urandom_range(0, 1));
            bus_a.in_tag    = tagc;
         end
         bus_a.out_ready = ($urandom_range(0, 99) < pr);
         @(negedge clk);
         if (sent < n && !bus_a.in_ready) rdy_low++;
         hold = bus_a.in_valid && !bus_a.in_ready;
         if (bus_a.in_valid && bus_a.in_ready) begin
            e.y = exp_a(bus_a.in_data, bus_a.in_center);
            e.tag = tagc;
            q_a.push_back(e);
            sent++;
            tagc++;
         end
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
               check("stream_extra_output", 1, 0);
            end else begin
               e = q_a.pop_front();
               check("stream_tag", bus_a.out_tag, e.tag);
               check("stream_data", bus_a.out_data, e.y);
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus_a.in_valid = 1'b0;
      bus_a.out_ready = 1'b1;
      if (cyc >= 60000) begin
         check("stream_timeout_pending", q_a.size(), 0);
         q_a.delete();
      end
   endtask

   task automatic stream_b(input int n);
      longint   bv [12];
      longint   xv;
      int       sent, cyc;
      bit       hold;
      logic [7:0] tagc;
      eb_t      e;
      bv = '{0, 1, 7680, 7681, 7682, 15362, 3840, 3841,
             (64'sd1 <<< 26) - 1, (64'sd1 <<< 26) - 2, 7680 * 7680, 8191 * 8191};
      sent = 0; cyc = 0; hold = 0; tagc = 8'd0;
      while ((sent < n || q_b.size() > 0) && cyc < 40000) begin
         if (!hold) begin
            xv = (sent < 12) ? bv[sent] : longint'($urandom_range(0, 32'h3FF_FFFF));
            bus_b.in_valid  = (sent < n);
            bus_b.in_data   = 26'(xv);
            bus_b.in_center = 1'($urandom_range(0, 1));
            bus_b.in_tag    = tagc;
         end
         bus_b.out_ready = ($urandom_range(0, 99) < 90);
         @(negedge clk);
         hold = bus_b.in_valid && !bus_b.in_ready;
         if (bus_b.in_valid && bus_b.in_ready) begin
            e.y = ref_b(longint'(bus_b.in_data), bus_b.in_center);
            e.tag = tagc;
            q_b.push_back(e);
            sent++;
            tagc++;
         end
         if (bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) begin
               check("alt_extra_output", 1, 0);
            end else begin
               e = q_b.pop_front();
               check("alt_tag", bus_b.out_tag, e.tag);
               check("alt_data", bus_b.out_data, e.y);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus_b.in_valid = 1'b0;
      bus_b.out_ready = 1'b1;
      if (cyc >= 40000) begin
         check("alt_timeout_pending", q_b.size(), 0);
         q_b.delete();
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [199:0] xs [3];
      logic [103:0] y_first;
      int           stale;

      // Directed vectors: lane 0 first in each list.
      tv[0] = '{px(0, QR, QR - 1, (QR - 1) * (QR - 1)), 1'b0, py(0, 0, QR - 1, 1)};
      tv[1] = '{px(16646144, 16646145, 33292288, 1), 1'b1, py(16646144, -16646144, -1, 1)};
      tv[2] = '{px(2 * QR + 5, 3 * QR + 7, QR * 1000000 + 12345, 1), 1'b0, py(5, 7, 12345, 1)};
      tv[3] = '{px(HR, HR + 1, QR * 30000000 + QR - 2, QR * 33800000 + 17), 1'b1,
                py(HR, -HR, -2, 17)};
      tv[4] = '{px(64'sd1 <<< 25, (64'sd1 <<< 50) - 1, 2 * QR - 1, 2), 1'b0,
                py(262143, 3667952, QR - 1, 2)};

      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_center = 1'b0; bus_a.in_tag = '0;
      bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_center = 1'b0; bus_b.in_tag = '0;
      bus_b.out_ready = 1'b1;

      // Reset state.
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus_a.out_valid, 0);
      check("rst_out_data", bus_a.out_data, 0);
      check("rst_out_tag", bus_a.out_tag, 0);
      check("rst_in_ready", bus_a.in_ready, 1);
      check("rst_alt_out_valid", bus_b.out_valid, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table with exact latency.
      bus_a.out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         bus_a.in_valid  = 1'b1;
         bus_a.in_data   = tv[v].x;
         bus_a.in_center = tv[v].c;
         bus_a.in_tag    = 8'(8'hA0 + v);
         #1;
         check("tbl_in_ready", bus_a.in_ready, 1);
         @(posedge clk); #1;
         bus_a.in_valid = 1'b0;
         check("tbl_valid_n0", bus_a.out_valid, 0);
         @(posedge clk); #1;
         check("tbl_valid_n1", bus_a.out_valid, 0);
         @(posedge clk); #1;
         check("tbl_valid_n2", bus_a.out_valid, 1);
         check("tbl_data", bus_a.out_data, tv[v].y);
         check("tbl_tag", bus_a.out_tag, 8'(8'hA0 + v));
         @(posedge clk); #1;
         check("tbl_drained", bus_a.out_valid, 0);
      end

      // Fill the pipe under stall, check hold, then reset mid-stall.
      bus_a.out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         xs[t] = px(longint'(t) * QR * 1000 + 3, QR + t, 7 * t + 1, (QR - 1) * (QR - 2) + t);
         bus_a.in_valid  = 1'b1;
         bus_a.in_data   = xs[t];
         bus_a.in_center = 1'(t);
         bus_a.in_tag    = 8'(8'h50 + t);
         @(posedge clk); #1;
      end
      bus_a.in_valid = 1'b0;
      y_first = exp_a(xs[0], 1'b0);
      check("stall_in_ready", bus_a.in_ready, 0);
      check("stall_out_valid", bus_a.out_valid, 1);
      check("stall_data", bus_a.out_data, y_first);
      repeat (2) @(posedge clk);
      #1;
      check("stall_hold_data", bus_a.out_data, y_first);
      check("stall_hold_tag", bus_a.out_tag, 8'h50);
      check("stall_hold_valid", bus_a.out_valid, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", bus_a.out_valid, 0);
      check("midrst_out_data", bus_a.out_data, 0);
      check("midrst_out_tag", bus_a.out_tag, 0);
      check("midrst_in_ready", bus_a.in_ready, 1);
      rst = 1'b1;
      bus_a.out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus_a.out_valid) stale++;
         @(posedge clk); #1;
      end
      check("midrst_no_stale", stale, 0);

      // Random streaming with back-pressure and mixed modes.
      stream_a(10000, 70, 50);
      check("stream_count", n_out, 10000);

      // Full rate.
      stream_a(100, 100, 100);
      check("full_count", n_out, 100);
      check("full_consecutive", last_out - first_out, 99);
      check("full_in_ready_low", rdy_low, 0);

      // Alternate shape q = 7681.
      stream_b(12000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
